// File: rtl/ft_frame_tx.sv
// FT2232H synchronous-FIFO transmit framer: START_FLAG, FRAME_LEN payload bytes from the
// sample FIFO, STOP_FLAG, then a done pulse. A 2-entry skid keeps one byte/cycle across TXE# stalls.
module ft_frame_tx #(
    parameter int unsigned           FRAME_LEN  = 40960,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] START_FLAG = 8'h5A,
    parameter logic [DATA_WIDTH-1:0] STOP_FLAG  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_req_i,
    output logic                  frame_done_o,
    output logic                  busy_o,
    input  logic                  fifo_empty_i,
    output logic                  fifo_ren_o,
    input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
    input  logic                  ft_txe_n_i,
    output logic                  ft_wr_n_o,
    output logic [DATA_WIDTH-1:0] ft_data_o
);

    localparam int unsigned      CNT_W    = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LEN_C    = CNT_W'(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE,
        S_REARM
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_skid0;
    logic [DATA_WIDTH-1:0] r_skid1;
    logic [1:0]            r_occ;
    logic                  r_inflight;
    logic [CNT_W-1:0]      r_sent_cnt;
    logic [CNT_W-1:0]      r_rd_cnt;

    logic                  w_have_byte;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_accept;
    logic                  w_pop;
    logic [1:0]            w_level;
    logic [1:0]            w_occ_after_pop;

    // Output decode, write handshake, read issue and next state
    always_comb begin
        w_next       = r_state;
        w_have_byte  = 1'b0;
        w_data       = '0;
        frame_done_o = 1'b0;
        busy_o       = 1'b1;

        case (r_state)
            S_IDLE:  busy_o = 1'b0;
            S_START: begin
                w_have_byte = 1'b1;
                w_data      = START_FLAG;
            end
            S_DATA: begin
                w_have_byte = (r_occ != 2'd0);
                w_data      = r_skid0;
            end
            S_STOP: begin
                w_have_byte = 1'b1;
                w_data      = STOP_FLAG;
            end
            S_DONE:  frame_done_o = 1'b1;
            default: ;
        endcase

        w_accept        = ~ft_txe_n_i & w_have_byte;
        w_pop           = (r_state == S_DATA) & w_accept;
        w_occ_after_pop = r_occ - {1'b0, w_pop};
        w_level         = w_occ_after_pop + {1'b0, r_inflight};
        ft_wr_n_o       = ~w_accept;
        ft_data_o       = w_data;

        // Skid level counts the in-flight byte so the 2-entry skid can never overflow
        fifo_ren_o = ((r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP))
                     & ~fifo_empty_i & (r_rd_cnt < LEN_C) & (w_level < 2'd2);

        case (r_state)
            S_IDLE:  if (frame_req_i) w_next = S_START;
            S_START: if (w_accept) w_next = S_DATA;
            S_DATA:  if (w_pop && (r_sent_cnt == LAST_IDX)) w_next = S_STOP;
            S_STOP:  if (w_accept) w_next = S_DONE;
            S_DONE:  w_next = S_REARM;
            S_REARM: if (!frame_req_i) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State, counters and skid storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_skid0    <= '0;
            r_skid1    <= '0;
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_sent_cnt <= '0;
            r_rd_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && frame_req_i) begin
                r_occ      <= 2'd0;
                r_inflight <= 1'b0;
                r_sent_cnt <= '0;
                r_rd_cnt   <= '0;
            end else begin
                r_inflight <= fifo_ren_o;
                r_occ      <= w_level;
                if (fifo_ren_o) r_rd_cnt <= r_rd_cnt + CNT_W'(1);
                if (w_pop) begin
                    r_sent_cnt <= r_sent_cnt + CNT_W'(1);
                    r_skid0    <= r_skid1;
                end
                // Landing byte goes to the first free slot after this cycle's pop
                if (r_inflight) begin
                    if (w_occ_after_pop == 2'd0) r_skid0 <= fifo_rdata_i;
                    else                         r_skid1 <= fifo_rdata_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_ft_frame_tx.sv
// Bench for ft_frame_tx: cycle table for a clean frame, hand sequences for stalls, FIFO gaps and
// reset, then random TXE#/empty frames scored against the expected flag-framed byte stream.
module tb_ft_frame_tx;

    localparam int unsigned FL = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_req_i = 1'b0;
    logic       frame_done_o;
    logic       busy_o;
    logic       fifo_empty_i = 1'b1;
    logic       fifo_ren_o;
    logic [7:0] fifo_rdata_i = 8'h00;
    logic       ft_txe_n_i = 1'b0;
    logic       ft_wr_n_o;
    logic [7:0] ft_data_o;

    ft_frame_tx #(.FRAME_LEN(FL)) dut (
        .clk          (clk),
        .rst          (rst),
        .frame_req_i  (frame_req_i),
        .frame_done_o (frame_done_o),
        .busy_o       (busy_o),
        .fifo_empty_i (fifo_empty_i),
        .fifo_ren_o   (fifo_ren_o),
        .fifo_rdata_i (fifo_rdata_i),
        .ft_txe_n_i   (ft_txe_n_i),
        .ft_wr_n_o    (ft_wr_n_o),
        .ft_data_o    (ft_data_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] wire_q[$];
    logic [7:0] exp_q[$];
    logic       force_empty = 1'b0;
    logic       ren_s = 1'b0;
    int acc_cnt = 0, done_cnt = 0, ren_cnt = 0, viol = 0, underflow = 0;

    // Observe the wire and the FIFO pops mid-cycle, where all inputs are settled
    always @(negedge clk) begin
        ren_s = fifo_ren_o;
        if (!rst) begin
            if (!ft_wr_n_o && !ft_txe_n_i) begin
                wire_q.push_back(ft_data_o);
                acc_cnt++;
            end
            if (!ft_wr_n_o && ft_txe_n_i) viol++;
            if (frame_done_o) done_cnt++;
            if (fifo_ren_o) ren_cnt++;
        end
    end

    // Read-side FIFO model: data appears the cycle after a pop
    always @(posedge clk) begin
        if (ren_s) begin
            if (fifo_q.size() > 0) fifo_rdata_i <= fifo_q.pop_front();
            else underflow++;
        end
        #2;
        fifo_empty_i = force_empty | (fifo_q.size() == 0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_stream(input string name);
        int bad = -1;
        checks++;
        if (wire_q.size() != exp_q.size()) bad = -2;
        else for (int i = 0; i < exp_q.size(); i++) if (bad < 0 && wire_q[i] !== exp_q[i]) bad = i;
        if (bad != -1) begin
            failures++;
            if (bad == -2) $display("FAIL %s stream length actual=%0d expected=%0d", name, wire_q.size(), exp_q.size());
            else $display("FAIL %s byte %0d actual=%0h expected=%0h", name, bad, wire_q[bad], exp_q[bad]);
        end
    endtask

    // Fill the FIFO with one frame's payload and build the expected wire stream
    task automatic load_frame(input bit rnd);
        logic [7:0] b;
        fifo_q.delete();
        exp_q.delete();
        wire_q.delete();
        exp_q.push_back(8'h5A);
        for (int i = 0; i < FL; i++) begin
            b = rnd ? 8'($urandom_range(0, 255)) : 8'(i + 1);
            fifo_q.push_back(b);
            exp_q.push_back(b);
        end
        exp_q.push_back(8'hA5);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int target, input string name);
        int c = 0;
        while (acc_cnt < target && c < 200) begin
            step();
            c++;
        end
        if (acc_cnt < target) check(name, 32'(acc_cnt), 32'(target));
    endtask

    // Hold request until the done pulse, then release and let REARM return to IDLE
    task automatic run_frame(input bit rnd, input string name);
        int d0 = done_cnt;
        bit ok = 1'b0;
        frame_req_i = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            step();
            ft_txe_n_i  = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
            force_empty = rnd ? ($urandom_range(0, 9) < 2) : 1'b0;
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 32'(ok), 32'd1);
        frame_req_i = 1'b0;
        ft_txe_n_i  = 1'b0;
        force_empty = 1'b0;
        repeat (3) step();
    endtask

    typedef struct {
        logic       req;
        logic       txe_n;
        logic       wr_n;
        logic [7:0] data;
        logic       ren;
        logic       done;
        logic       busy;
    } vec_t;

    vec_t tbl[17];
    int   a0, d0, r0, v0;

    initial begin
        // One clean frame from IDLE through REARM, req held past DONE then dropped
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
        for (int i = 3; i <= 10; i++)
            tbl[i] = '{1'b1, 1'b0, 1'b0, 8'(i - 2), (i <= 8), 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};

        load_frame(1'b0);
        fifo_q.push_back(8'h09);
        fifo_q.push_back(8'h0A);
        repeat (2) step();
        check("reset_wr_n", 32'(ft_wr_n_o), 32'd1);
        check("reset_data", 32'(ft_data_o), 32'd0);
        check("reset_ren", 32'(fifo_ren_o), 32'd0);
        check("reset_done", 32'(frame_done_o), 32'd0);
        check("reset_busy", 32'(busy_o), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            step();
            frame_req_i = tbl[i].req;
            ft_txe_n_i  = tbl[i].txe_n;
            @(negedge clk);
            check($sformatf("tbl%0d_wr_n", i), 32'(ft_wr_n_o), 32'(tbl[i].wr_n));
            if (!tbl[i].wr_n) check($sformatf("tbl%0d_data", i), 32'(ft_data_o), 32'(tbl[i].data));
            check($sformatf("tbl%0d_ren", i), 32'(fifo_ren_o), 32'(tbl[i].ren));
            check($sformatf("tbl%0d_done", i), 32'(frame_done_o), 32'(tbl[i].done));
            check($sformatf("tbl%0d_busy", i), 32'(busy_o), 32'(tbl[i].busy));
        end
        check_stream("tbl_stream");
        check("tbl_fifo_left", 32'(fifo_q.size()), 32'd2);
        check("tbl_ren_count", 32'(ren_cnt), 32'(FL));
        check("tbl_done_count", 32'(done_cnt), 32'd1);
        step();

        // TXE# high for 3 cycles right after the 3rd payload byte
        load_frame(1'b1);
        step();
        d0 = done_cnt;
        frame_req_i = 1'b1;
        wait_acc(acc_cnt + 4, "stall_reach");
        a0 = acc_cnt;
        v0 = viol;
        ft_txe_n_i = 1'b1;
        repeat (3) step();
        ft_txe_n_i = 1'b0;
        check("stall_no_accept", 32'(acc_cnt), 32'(a0));
        run_frame(1'b0, "stall_done");
        check_stream("stall_stream");
        check("stall_viol", 32'(viol), 32'(v0));
        check("stall_done_count", 32'(done_cnt - d0), 32'd1);

        // FIFO empty for 5 cycles mid-frame: only already-fetched bytes may drain
        load_frame(1'b1);
        step();
        r0 = ren_cnt;
        frame_req_i = 1'b1;
        wait_acc(acc_cnt + 5, "gap_reach");
        force_empty = 1'b1;
        step();
        a0 = acc_cnt;
        repeat (5) step();
        force_empty = 1'b0;
        checks++;
        if (acc_cnt - a0 > 2) begin
            failures++;
            $display("FAIL gap_drain actual=%0d expected<=2", acc_cnt - a0);
        end
        run_frame(1'b0, "gap_done");
        check_stream("gap_stream");
        check("gap_ren_count", 32'(ren_cnt - r0), 32'(FL));

        // Reset while the 3rd payload byte has just gone out
        load_frame(1'b1);
        step();
        d0 = done_cnt;
        frame_req_i = 1'b1;
        wait_acc(acc_cnt + 4, "rst_reach");
        rst = 1'b1;
        #3;
        check("rst_wr_n", 32'(ft_wr_n_o), 32'd1);
        check("rst_data", 32'(ft_data_o), 32'd0);
        check("rst_ren", 32'(fifo_ren_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        step();
        rst = 1'b0;
        frame_req_i = 1'b0;
        repeat (3) step();
        check("rst_no_done", 32'(done_cnt), 32'(d0));
        load_frame(1'b1);
        step();
        run_frame(1'b0, "rst_restart_done");
        check_stream("rst_restart_stream");

        // Random TXE# and FIFO-empty gaps over many frames
        for (int f = 0; f < 15; f++) begin
            load_frame(1'b1);
            step();
            d0 = done_cnt;
            r0 = ren_cnt;
            run_frame(1'b1, $sformatf("rand%0d_done", f));
            check_stream($sformatf("rand%0d_stream", f));
            check($sformatf("rand%0d_reads", f), 32'(ren_cnt - r0), 32'(FL));
            check($sformatf("rand%0d_done_count", f), 32'(done_cnt - d0), 32'd1);
        end

        check("no_write_during_txe_high", 32'(viol), 32'd0);
        check("no_fifo_underflow", 32'(underflow), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
